// File: rtl/crc16_rx_check_if.sv
// Byte-stream link between the receive deframer and its neighbours.
// The slave side is the CRC checker; the master side drives received bytes and consumes payload/status.
interface crc16_rx_check_if #(
  parameter int LEN_W = 16
);
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_sop;
  logic             in_eop;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_sop;
  logic             out_eop;
  logic             out_abort;
  logic             frame_done;
  logic             crc_ok;
  logic             len_err;
  logic [15:0]      crc_calc;
  logic [LEN_W-1:0] frame_len;

  modport slave (
    input  in_data, in_valid, in_sop, in_eop,
    output out_data, out_valid, out_sop, out_eop, out_abort,
    output frame_done, crc_ok, len_err, crc_calc, frame_len
  );

  modport master (
    output in_data, in_valid, in_sop, in_eop,
    input  out_data, out_valid, out_sop, out_eop, out_abort,
    input  frame_done, crc_ok, len_err, crc_calc, frame_len
  );
endinterface

// File: rtl/crc16_rx_check.sv
// Receive-side CRC-16 checker: strips the trailing 2-byte CRC, forwards the payload
// two beats late, and reports pass/fail, payload length and framing errors per frame.
module crc16_rx_check #(
  parameter logic [15:0] INIT  = 16'hFFFF,
  parameter int          LEN_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  crc16_rx_check_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FILL1, FILL2, RUN} state_t;

  state_t           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [7:0]       s0_q, s0_d;
  logic [7:0]       s1_q, s1_d;

  logic [7:0]       outData_q, outData_d;
  logic             outValid_q, outValid_d;
  logic             outSop_q, outSop_d;
  logic             outEop_q, outEop_d;
  logic             outAbort_q, outAbort_d;
  logic             frameDone_q, frameDone_d;
  logic             crcOk_q, crcOk_d;
  logic             lenErr_q, lenErr_d;
  logic [15:0]      crcCalc_q, crcCalc_d;
  logic [LEN_W-1:0] frameLen_q, frameLen_d;

  logic [15:0]      crcNext;
  logic             shortFrame;

  // Same byte-parallel update as the transmit generator (poly 0x8005, MSB first).
  function automatic logic [15:0] crcUpdate(input logic [15:0] q, input logic [7:0] d);
    logic [7:0]  t;
    logic        p;
    logic [15:0] c;
    t = q[15:8] ^ d;
    p = ^t;
    c[0]     = p;
    c[1]     = ^t[7:1];
    c[2]     = t[0] ^ t[1];
    c[3]     = t[1] ^ t[2];
    c[4]     = t[2] ^ t[3];
    c[5]     = t[3] ^ t[4];
    c[6]     = t[4] ^ t[5];
    c[7]     = t[5] ^ t[6];
    c[8]     = q[0] ^ t[6] ^ t[7];
    c[9]     = q[1] ^ t[7];
    c[14:10] = q[6:2];
    c[15]    = q[7] ^ p;
    return c;
  endfunction

  assign crcNext = crcUpdate(lfsr_q, s1_q);

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    cnt_d       = cnt_q;
    s0_d        = s0_q;
    s1_d        = s1_q;
    outData_d   = outData_q;
    outValid_d  = 1'b0;
    outSop_d    = 1'b0;
    outEop_d    = 1'b0;
    outAbort_d  = 1'b0;
    frameDone_d = 1'b0;
    crcOk_d     = crcOk_q;
    lenErr_d    = lenErr_q;
    crcCalc_d   = crcCalc_q;
    frameLen_d  = frameLen_q;
    shortFrame  = 1'b0;

    if (bus.in_valid) begin
      s0_d = bus.in_data;
      s1_d = s0_q;
      if (bus.in_sop) begin
        // A new sop always wins; only a frame that already showed out_sop needs an abort.
        outAbort_d = (state_q == RUN);
        if (bus.in_eop) begin
          shortFrame = 1'b1;
        end else begin
          state_d = FILL1;
          lfsr_d  = INIT;
          cnt_d   = '0;
        end
      end else begin
        case (state_q)
          IDLE: state_d = IDLE;
          FILL1: begin
            if (bus.in_eop) shortFrame = 1'b1;
            else            state_d = FILL2;
          end
          FILL2, RUN: begin
            outValid_d = 1'b1;
            outData_d  = s1_q;
            outSop_d   = (state_q == FILL2);
            if (bus.in_eop) begin
              // s0 and the current byte are the received CRC, high byte first.
              outEop_d    = 1'b1;
              frameDone_d = 1'b1;
              crcOk_d     = (crcNext == {s0_q, bus.in_data});
              crcCalc_d   = crcNext;
              frameLen_d  = cnt_q + LEN_W'(1);
              lenErr_d    = 1'b0;
              state_d     = IDLE;
            end else begin
              lfsr_d  = crcNext;
              cnt_d   = (&cnt_q) ? cnt_q : cnt_q + LEN_W'(1);
              state_d = RUN;
            end
          end
          default: state_d = IDLE;
        endcase
      end

      if (shortFrame) begin
        frameDone_d = 1'b1;
        lenErr_d    = 1'b1;
        crcOk_d     = 1'b0;
        frameLen_d  = '0;
        crcCalc_d   = INIT;
        state_d     = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lfsr_q      <= INIT;
      cnt_q       <= '0;
      s0_q        <= '0;
      s1_q        <= '0;
      outData_q   <= '0;
      outValid_q  <= 1'b0;
      outSop_q    <= 1'b0;
      outEop_q    <= 1'b0;
      outAbort_q  <= 1'b0;
      frameDone_q <= 1'b0;
      crcOk_q     <= 1'b0;
      lenErr_q    <= 1'b0;
      crcCalc_q   <= '0;
      frameLen_q  <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      cnt_q       <= cnt_d;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      outData_q   <= outData_d;
      outValid_q  <= outValid_d;
      outSop_q    <= outSop_d;
      outEop_q    <= outEop_d;
      outAbort_q  <= outAbort_d;
      frameDone_q <= frameDone_d;
      crcOk_q     <= crcOk_d;
      lenErr_q    <= lenErr_d;
      crcCalc_q   <= crcCalc_d;
      frameLen_q  <= frameLen_d;
    end
  end

  assign bus.out_data   = outData_q;
  assign bus.out_valid  = outValid_q;
  assign bus.out_sop    = outSop_q;
  assign bus.out_eop    = outEop_q;
  assign bus.out_abort  = outAbort_q;
  assign bus.frame_done = frameDone_q;
  assign bus.crc_ok     = crcOk_q;
  assign bus.len_err    = lenErr_q;
  assign bus.crc_calc   = crcCalc_q;
  assign bus.frame_len  = frameLen_q;

endmodule

// File: tb/tb_crc16_rx_check.sv
// Self-checking bench for crc16_rx_check: random framed traffic compared against a
// bit-serial CRC reference and per-frame expectations kept in queues.
module tb_crc16_rx_check;

  logic clk;
  logic rst;

  crc16_rx_check_if #(.LEN_W(16)) bus ();

  crc16_rx_check #(.INIT(16'hFFFF), .LEN_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;

  logic [7:0]  pay[$];
  logic [7:0]  txBytes[$];
  logic [15:0] expCrc;

  logic [7:0]  rxData[$];
  bit          rxSop[$];
  bit          rxEop[$];
  bit          doneOk[$];
  bit          doneLenErr[$];
  logic [15:0] doneCrc[$];
  logic [15:0] doneLen[$];
  int          abortCount;

  // Observe the output side away from the active edge and log every event.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid) begin
        rxData.push_back(bus.out_data);
        rxSop.push_back(bus.out_sop);
        rxEop.push_back(bus.out_eop);
      end
      if (bus.frame_done) begin
        doneOk.push_back(bus.crc_ok);
        doneLenErr.push_back(bus.len_err);
        doneCrc.push_back(bus.crc_calc);
        doneLen.push_back(bus.frame_len);
      end
      if (bus.out_abort) abortCount++;
    end
  end

  // Bit-serial CRC-16 reference, poly 0x8005, MSB first, seed 0xFFFF.
  function automatic logic [15:0] crcOfPay();
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (pay[i]) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ pay[i][b];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    end
    return c;
  endfunction

  task automatic makeFrame(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
    expCrc  = crcOfPay();
    txBytes = pay;
    txBytes.push_back(expCrc[15:8]);
    txBytes.push_back(expCrc[7:0]);
  endtask

  task automatic clearMon();
    rxData.delete(); rxSop.delete(); rxEop.delete();
    doneOk.delete(); doneLenErr.delete(); doneCrc.delete(); doneLen.delete();
    abortCount = 0;
  endtask

  task automatic sendBeat(input logic [7:0] d, input bit sop, input bit eop, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        bus.in_sop   = 1'($urandom);
        bus.in_eop   = 1'($urandom);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sop   = sop;
    bus.in_eop   = eop;
  endtask

  task automatic endIdle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    bus.in_eop   = 1'b0;
  endtask

  task automatic sendFrame(input bit gaps);
    for (int i = 0; i < txBytes.size(); i++)
      sendBeat(txBytes[i], i == 0, i == txBytes.size() - 1, gaps);
    endIdle();
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    nChecks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %0b expected 0", bus.out_valid); else nPass++;
    nChecks++; if (bus.frame_done !== 1'b0) $display("[TB] FAIL reset_frame_done: got %0b expected 0", bus.frame_done); else nPass++;
    nChecks++; if (bus.out_abort !== 1'b0) $display("[TB] FAIL reset_out_abort: got %0b expected 0", bus.out_abort); else nPass++;
    nChecks++; if ({bus.crc_ok, bus.len_err, bus.out_sop, bus.out_eop} !== 4'b0)
      $display("[TB] FAIL reset_flags: got %04b expected 0000", {bus.crc_ok, bus.len_err, bus.out_sop, bus.out_eop}); else nPass++;
    nChecks++; if ({bus.crc_calc, bus.frame_len, bus.out_data} !== 40'h0)
      $display("[TB] FAIL reset_fields: got %h expected 0", {bus.crc_calc, bus.frame_len, bus.out_data}); else nPass++;
    @(negedge clk);
    rst = 1'b0;
    clearMon();
  endtask

  task automatic test_good_frame();
    clearMon();
    txBytes = '{8'h00, 8'hFD, 8'h02};
    for (int i = 0; i < 3; i++) sendBeat(txBytes[i], i == 0, i == 2, 1'b0);
    endIdle();
    #1;
    nChecks++; if ({bus.out_valid, bus.out_sop, bus.out_eop, bus.out_data} !== {3'b111, 8'h00})
      $display("[TB] FAIL good_out_beat: got %b_%h expected 111_00", {bus.out_valid, bus.out_sop, bus.out_eop}, bus.out_data); else nPass++;
    nChecks++; if ({bus.frame_done, bus.crc_ok, bus.len_err} !== 3'b110)
      $display("[TB] FAIL good_status: got %03b expected 110", {bus.frame_done, bus.crc_ok, bus.len_err}); else nPass++;
    nChecks++; if (bus.crc_calc !== 16'hFD02) $display("[TB] FAIL good_crc_calc: got %h expected fd02", bus.crc_calc); else nPass++;
    nChecks++; if (bus.frame_len !== 16'd1) $display("[TB] FAIL good_frame_len: got %0d expected 1", bus.frame_len); else nPass++;
    settle();
    nChecks++; if ({bus.frame_done, bus.crc_ok, bus.crc_calc} !== {2'b01, 16'hFD02})
      $display("[TB] FAIL good_status_hold: got %b_%h expected 01_fd02", {bus.frame_done, bus.crc_ok}, bus.crc_calc); else nPass++;
    nChecks++; if (rxData.size() !== 1 || doneOk.size() !== 1)
      $display("[TB] FAIL good_event_count: got %0d beats %0d dones expected 1 1", rxData.size(), doneOk.size()); else nPass++;
  endtask

  task automatic test_corrupt_crc();
    clearMon();
    txBytes = '{8'h00, 8'hFD, 8'h03};
    sendFrame(1'b0);
    settle();
    nChecks++; if (rxData.size() !== 1 || (rxData.size() == 1 && rxData[0] !== 8'h00))
      $display("[TB] FAIL corrupt_payload: got %0d beats expected one 00 beat", rxData.size()); else nPass++;
    nChecks++; if (doneOk.size() !== 1 || (doneOk.size() == 1 && (doneOk[0] !== 1'b0 || doneCrc[0] !== 16'hFD02)))
      $display("[TB] FAIL corrupt_status: got %0d dones ok=%0b crc=%h expected 1 ok=0 crc=fd02",
               doneOk.size(), bus.crc_ok, bus.crc_calc); else nPass++;
  endtask

  task automatic test_round_trip();
    int n, bad, nSop, nEop;
    for (int f = 0; f < 24; f++) begin
      clearMon();
      n = (f == 0) ? 1 : (f == 1) ? 64 : int'($urandom_range(1, 64));
      makeFrame(n);
      if ($urandom_range(0, 2) == 0) begin
        sendBeat(8'($urandom), 1'b0, 1'($urandom), 1'b0);
        endIdle();
      end
      sendFrame(1'b1);
      settle();
      bad = 0; nSop = 0; nEop = 0;
      foreach (rxData[i]) begin
        if (i >= n || rxData[i] !== pay[i]) bad++;
        if (rxSop[i]) nSop++;
        if (rxEop[i]) nEop++;
      end
      nChecks++; if (rxData.size() !== n || bad !== 0)
        $display("[TB] FAIL rt_payload f%0d: got %0d beats %0d wrong expected %0d beats 0 wrong", f, rxData.size(), bad, n); else nPass++;
      nChecks++; if (nSop !== 1 || nEop !== 1 || !rxSop[0] || !rxEop[rxData.size()-1])
        $display("[TB] FAIL rt_framing f%0d: got sop=%0d eop=%0d expected one each at ends", f, nSop, nEop); else nPass++;
      nChecks++; if (doneOk.size() !== 1)
        $display("[TB] FAIL rt_done_count f%0d: got %0d expected 1", f, doneOk.size()); else nPass++;
      if (doneOk.size() == 1) begin
        nChecks++; if ({doneOk[0], doneLenErr[0], doneLen[0], doneCrc[0]} !== {2'b10, 16'(n), expCrc})
          $display("[TB] FAIL rt_status f%0d: got ok=%0b lerr=%0b len=%0d crc=%h expected ok=1 lerr=0 len=%0d crc=%h",
                   f, doneOk[0], doneLenErr[0], doneLen[0], doneCrc[0], n, expCrc); else nPass++;
      end
    end
  endtask

  task automatic test_short_frames();
    for (int k = 1; k <= 2; k++) begin
      clearMon();
      txBytes.delete();
      for (int i = 0; i < k; i++) txBytes.push_back(8'($urandom));
      sendFrame(1'b0);
      settle();
      nChecks++; if (rxData.size() !== 0)
        $display("[TB] FAIL short%0d_no_payload: got %0d beats expected 0", k, rxData.size()); else nPass++;
      nChecks++; if (doneOk.size() !== 1 || (doneOk.size() == 1 &&
                     {doneOk[0], doneLenErr[0], doneLen[0], doneCrc[0]} !== {2'b01, 16'd0, 16'hFFFF}))
        $display("[TB] FAIL short%0d_status: got %0d dones ok=%0b lerr=%0b len=%0d crc=%h expected 1 ok=0 lerr=1 len=0 crc=ffff",
                 k, doneOk.size(), bus.crc_ok, bus.len_err, bus.frame_len, bus.crc_calc); else nPass++;
    end
  endtask

  task automatic test_abort();
    logic [7:0] old[$];
    int         n, bad;
    clearMon();
    makeFrame(10);
    old = pay;
    for (int i = 0; i < 7; i++) sendBeat(txBytes[i], i == 0, 1'b0, 1'b1);
    n = int'($urandom_range(3, 20));
    makeFrame(n);
    sendFrame(1'b1);
    settle();
    bad = 0;
    foreach (rxData[i]) begin
      if (i < 5 && (rxData[i] !== old[i] || rxEop[i])) bad++;
      if (i >= 5 && (i - 5 >= n || rxData[i] !== pay[i-5])) bad++;
    end
    nChecks++; if (abortCount !== 1) $display("[TB] FAIL abort_pulse: got %0d expected 1", abortCount); else nPass++;
    nChecks++; if (rxData.size() !== 5 + n || bad !== 0)
      $display("[TB] FAIL abort_stream: got %0d beats %0d wrong expected %0d beats 0 wrong", rxData.size(), bad, 5 + n); else nPass++;
    nChecks++; if (doneOk.size() !== 1 || (doneOk.size() == 1 && (doneOk[0] !== 1'b1 || doneLen[0] !== 16'(n))))
      $display("[TB] FAIL abort_next_frame: got %0d dones ok=%0b len=%0d expected 1 ok=1 len=%0d",
               doneOk.size(), bus.crc_ok, bus.frame_len, n); else nPass++;

    // Restart before any payload left: no abort pulse.
    clearMon();
    sendBeat(8'($urandom), 1'b1, 1'b0, 1'b0);
    sendBeat(8'($urandom), 1'b0, 1'b0, 1'b0);
    makeFrame(4);
    sendFrame(1'b0);
    settle();
    nChecks++; if (abortCount !== 0 || rxData.size() !== 4 || doneOk.size() !== 1)
      $display("[TB] FAIL early_restart: got abort=%0d beats=%0d dones=%0d expected 0 4 1",
               abortCount, rxData.size(), doneOk.size()); else nPass++;
  endtask

  task automatic test_reset_mid_frame();
    clearMon();
    makeFrame(12);
    for (int i = 0; i < 6; i++) sendBeat(txBytes[i], i == 0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
    #1;
    nChecks++; if ({bus.out_valid, bus.frame_done, bus.out_abort, bus.crc_calc, bus.frame_len, bus.out_data} !== 43'h0)
      $display("[TB] FAIL midreset_outputs: got %h expected 0",
               {bus.out_valid, bus.frame_done, bus.out_abort, bus.crc_calc, bus.frame_len, bus.out_data}); else nPass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    settle();
    nChecks++; if (doneOk.size() !== 0 || abortCount !== 0)
      $display("[TB] FAIL midreset_spurious: got %0d dones %0d aborts expected 0 0", doneOk.size(), abortCount); else nPass++;
    clearMon();
    makeFrame(int'($urandom_range(1, 30)));
    sendFrame(1'b1);
    settle();
    nChecks++; if (doneOk.size() !== 1 || (doneOk.size() == 1 && (doneOk[0] !== 1'b1 || doneCrc[0] !== expCrc)) ||
                   rxData.size() !== pay.size())
      $display("[TB] FAIL midreset_next_frame: got %0d dones %0d beats crc=%h expected 1 %0d crc=%h",
               doneOk.size(), rxData.size(), bus.crc_calc, pay.size(), expCrc); else nPass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] both[$];
    int         n1, n2, bad;
    logic [7:0] expPay[$];
    clearMon();
    n1 = int'($urandom_range(1, 10));
    n2 = int'($urandom_range(1, 10));
    makeFrame(n1);
    expPay = pay;
    both   = txBytes;
    makeFrame(n2);
    expPay = {expPay, pay};
    txBytes = {both, txBytes};
    for (int i = 0; i < txBytes.size(); i++)
      sendBeat(txBytes[i], (i == 0) || (i == n1 + 2), (i == n1 + 1) || (i == txBytes.size() - 1), 1'b0);
    endIdle();
    settle();
    bad = 0;
    foreach (rxData[i]) if (i >= expPay.size() || rxData[i] !== expPay[i]) bad++;
    nChecks++; if (rxData.size() !== n1 + n2 || bad !== 0)
      $display("[TB] FAIL b2b_payload: got %0d beats %0d wrong expected %0d beats", rxData.size(), bad, n1 + n2); else nPass++;
    nChecks++; if (doneOk.size() !== 2 || (doneOk.size() == 2 &&
                   {doneOk[0], doneOk[1], doneLen[0], doneLen[1]} !== {2'b11, 16'(n1), 16'(n2)}))
      $display("[TB] FAIL b2b_status: got %0d dones expected 2 ok frames len %0d %0d", doneOk.size(), n1, n2); else nPass++;
  endtask

  initial begin
    abortCount = 0;
    test_reset();
    test_good_frame();
    test_corrupt_crc();
    test_round_trip();
    test_short_frames();
    test_abort();
    test_reset_mid_frame();
    test_back_to_back();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
